// File: rtl/axi_lite_slave_regs.sv
// AXI4-lite slave fronting a DEPTH x DATA_WIDTH register file, one transaction at a time.
// Optional: define AXI_SLV_DECERR_EN to decode upper address bits and answer DECERR out of range.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, W_NEED_D, W_NEED_A, W_RESP, R_RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_W-1:0]       wr_strb;
    logic                    wr_ok, rd_ok;
    logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
    logic                    unused_ok;

    assign wr_idx = wr_addr[LSB +: DEPTH_LOG2];
    assign rd_idx = ARADDR[LSB +: DEPTH_LOG2];

`ifdef AXI_SLV_DECERR_EN
    assign wr_ok = (wr_addr >> (LSB + DEPTH_LOG2)) == '0;
    assign rd_ok = (ARADDR >> (LSB + DEPTH_LOG2)) == '0;
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    assign unused_ok = ^{AWPROT, ARPROT, wr_addr, ARADDR};

    // Readies are gated with reset so nothing is accepted while ARESETn is low.
    assign AWREADY = ARESETn && (state_q == IDLE || state_q == W_NEED_A);
    assign WREADY  = ARESETn && (state_q == IDLE || state_q == W_NEED_D);
    assign ARREADY = ARESETn && (state_q == IDLE) && !AWVALID && !WVALID;
    assign BVALID  = (state_q == W_RESP);
    assign RVALID  = (state_q == R_RESP);
    assign BRESP   = bresp_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        wr_en    = 1'b0;
        wr_addr  = AWADDR;
        wr_data  = WDATA;
        wr_strb  = WSTRB;
        case (state_q)
            IDLE: begin
                if (AWVALID && WVALID) begin
                    wr_en   = 1'b1;
                    state_d = W_RESP;
                end else if (AWVALID) begin
                    awaddr_d = AWADDR;
                    state_d  = W_NEED_D;
                end else if (WVALID) begin
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                    state_d = W_NEED_A;
                end else if (ARVALID) begin
                    rdata_d = rd_ok ? mem_q[rd_idx] : '0;
                    rresp_d = rd_ok ? RESP_OKAY : RESP_DECERR;
                    state_d = R_RESP;
                end
            end
            W_NEED_D: begin
                wr_addr = awaddr_q;
                if (WVALID) begin
                    wr_en   = 1'b1;
                    state_d = W_RESP;
                end
            end
            W_NEED_A: begin
                wr_data = wdata_q;
                wr_strb = wstrb_q;
                if (AWVALID) begin
                    wr_en   = 1'b1;
                    state_d = W_RESP;
                end
            end
            W_RESP:  if (BREADY) state_d = IDLE;
            R_RESP:  if (RREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wr_en) bresp_d = wr_ok ? RESP_OKAY : RESP_DECERR;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // Byte-lane commit on the edge completing the second of the AW/W handshakes.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: directed cases plus randomized traffic against a word-array model.
module tb_axi_lite_slave_regs;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

    logic [1:0]  bq [$];
    rexp_t       rq [$];
    logic [31:0] mem_m [16];
    int          errors = 0;
    int          checks = 0;

    axi_lite_slave_regs dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_SLV_DECERR_EN
        return a < 32'd64;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Called at posedge+1 with valid(s) just driven; returns at posedge+1 after the handshake edge.
    task automatic hs(input string nm, input bit need_aw, input bit need_w, input bit need_ar);
        int n = 0;
        #1;
        while (!((!need_aw || AWREADY) && (!need_w || WREADY) && (!need_ar || ARREADY)) && n < 50) begin
            tick();
            #1;
            n++;
        end
        if (n >= 50) chk({nm, "_timeout"}, 64'd1, 64'd0);
        tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int mode, input int gap, input int bdly);
        logic [1:0] exp_resp;
        exp_resp = in_range(addr) ? 2'b00 : 2'b11;
        if (in_range(addr))
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_m[widx(addr)][8*b +: 8] = data[8*b +: 8];
        bq.push_back(exp_resp);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        if (mode == 0) begin
            AWVALID = 1'b1; WVALID = 1'b1;
            hs("aw_w", 1'b1, 1'b1, 1'b0);
            AWVALID = 1'b0; WVALID = 1'b0;
        end else if (mode == 1) begin
            AWVALID = 1'b1; hs("aw", 1'b1, 1'b0, 1'b0); AWVALID = 1'b0;
            repeat (gap) tick();
            WVALID = 1'b1;  hs("w", 1'b0, 1'b1, 1'b0);  WVALID = 1'b0;
        end else begin
            WVALID = 1'b1;  hs("w", 1'b0, 1'b1, 1'b0);  WVALID = 1'b0;
            repeat (gap) tick();
            AWVALID = 1'b1; hs("aw", 1'b1, 1'b0, 1'b0); AWVALID = 1'b0;
        end
        #1;
        chk("b_latency", BVALID, 1'b1);
        for (int i = 0; i < bdly; i++) begin
            chk("b_hold_valid", BVALID, 1'b1);
            chk("b_hold_resp", BRESP, exp_resp);
            chk("b_hold_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
            tick();
            #1;
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input int rdly);
        rexp_t e;
        e.data = in_range(addr) ? mem_m[widx(addr)] : 32'h0;
        e.resp = in_range(addr) ? 2'b00 : 2'b11;
        rq.push_back(e);
        ARADDR = addr; ARVALID = 1'b1;
        hs("ar", 1'b0, 1'b0, 1'b1);
        ARVALID = 1'b0;
        #1;
        chk("r_latency", RVALID, 1'b1);
        for (int i = 0; i < rdly; i++) begin
            chk("r_hold_valid", RVALID, 1'b1);
            chk("r_hold_data", RDATA, e.data);
            chk("r_hold_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
            tick();
            #1;
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        rexp_t re;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
        AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; AWPROT = 0; ARPROT = 0;
        ARESETn = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;

        fork
            forever begin
                @(negedge ACLK);
                if (BVALID && BREADY) begin
                    if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                    else chk("bresp", BRESP, bq.pop_front());
                end
                if (RVALID && RREADY) begin
                    if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                    else begin
                        re = rq.pop_front();
                        chk("rdata", RDATA, re.data);
                        chk("rresp", RRESP, re.resp);
                    end
                end
            end
        join_none

        #12;
        chk("reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, 64'h0);
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
        #1;
        chk("idle_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();

        wr(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(32'h8, 0);
        wr(32'h4, 32'h11223344, 4'h5, 2, 3, 0);
        rd(32'h4, 0);

        // AR tied with AW+W: write must win and the read must see it
        AWADDR = 32'h10; WDATA = 32'hA5A5_1234; WSTRB = 4'hF; ARADDR = 32'h10;
        mem_m[4] = 32'hA5A5_1234;
        bq.push_back(2'b00);
        re.data = 32'hA5A5_1234; re.resp = 2'b00;
        rq.push_back(re);
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        #1;
        chk("tie_arready", ARREADY, 1'b0);
        chk("tie_aw_w_ready", {AWREADY, WREADY}, 2'b11);
        tick();
        AWVALID = 0; WVALID = 0;
        #1;
        chk("tie_bvalid", BVALID, 1'b1);
        chk("tie_arready_wresp", ARREADY, 1'b0);
        BREADY = 1;
        tick();
        BREADY = 0;
        #1;
        chk("tie_arready_after", ARREADY, 1'b1);
        tick();
        ARVALID = 0;
        #1;
        chk("tie_rvalid", RVALID, 1'b1);
        RREADY = 1;
        tick();
        RREADY = 0;

        wr(32'hC, 32'h0BAD_F00D, 4'hF, 1, 1, 5);
        rd(32'hC, 5);
        wr(32'h100, 32'hCAFE_F00D, 4'hF, 0, 0, 1);
        rd(32'h100, 0);
        rd(32'h0, 0);

        // Reset while AW is held waiting for W
        AWADDR = 32'h14; AWVALID = 1;
        hs("aw_rst", 1'b1, 1'b0, 1'b0);
        AWVALID = 0;
        #1;
        chk("need_d_readies", {AWREADY, WREADY}, 2'b01);
        WDATA = 32'h7777_7777; WSTRB = 4'hF; WVALID = 1;
        #1;
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, 64'h0);
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        tick();
        WVALID = 0;
        tick();
        ARESETn = 1'b1;
        tick();
        rd(32'h14, 0);
        rd(32'h8, 0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = $urandom_range(0, 32'h9F);
            if ($urandom_range(0, 1) == 0)
                wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            else
                rd(a, int'($urandom_range(0, 3)));
        end

        repeat (2) tick();
        chk("b_pending", bq.size(), 0);
        chk("r_pending", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
